matrix_stream_io: RTL and testbench

MATRIX_STREAM_IO -- requirements
Module: matrix_stream_io

---
 rtl/matrix_stream_io.sv | 143 ++++++++++++++
 tb/tb_matrix_stream_io.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_io.sv
// Stream-to-parallel adapter around a matrix-vector engine: gathers a vector and a matrix word by word,
// fires the engine once, then serialises the engine's result vector back out with valid/ready handshakes.
module matrix_stream_io #(
  parameter int DATA_SIZE      = 16,
  parameter int COLUMN_SIZE    = 64,
  parameter int ROW_SIZE       = 64,
  parameter int ENGINE_LATENCY = 1
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [DATA_SIZE-1:0]                     in_data,
  output logic [DATA_SIZE*COLUMN_SIZE-1:0]         datsA,
  output logic [DATA_SIZE*COLUMN_SIZE*ROW_SIZE-1:0] datsB,
  output logic                                     mat_enable,
  input  logic [DATA_SIZE*COLUMN_SIZE-1:0]         datsOut,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [DATA_SIZE-1:0]                     out_data,
  output logic                                     out_last,
  output logic                                     busy
);

  localparam int A_WORDS   = COLUMN_SIZE;
  localparam int B_WORDS   = COLUMN_SIZE * ROW_SIZE;
  localparam int MAX_COUNT = (B_WORDS > ENGINE_LATENCY) ? B_WORDS : ENGINE_LATENCY;
  localparam int CNT_W     = $clog2(MAX_COUNT + 1);

  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A_WORDS - 1);
  localparam logic [CNT_W-1:0] B_LAST = CNT_W'(B_WORDS - 1);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(ENGINE_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    FIRE,
    WAIT,
    DRAIN
  } state_e;

  state_e                                  state_q, state_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic [DATA_SIZE*COLUMN_SIZE-1:0]        dats_a_q, dats_a_d;
  logic [DATA_SIZE*COLUMN_SIZE*ROW_SIZE-1:0] dats_b_q, dats_b_d;
  logic [DATA_SIZE*COLUMN_SIZE-1:0]        result_q, result_d;

  logic in_hs;
  logic out_hs;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      dats_a_q <= '0;
      dats_b_q <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      dats_a_q <= dats_a_d;
      dats_b_q <= dats_b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A: if (in_hs && cnt_q == A_LAST) state_d = LOAD_B;
      LOAD_B: if (in_hs && cnt_q == B_LAST) state_d = FIRE;
      FIRE:   state_d = WAIT;
      WAIT:   if (cnt_q == W_LAST) state_d = DRAIN;
      DRAIN:  if (out_hs && cnt_q == A_LAST) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  // One shared counter serves as load index, latency timer and drain index, since the phases never overlap.
  always_comb begin
    cnt_d    = cnt_q;
    dats_a_d = dats_a_q;
    dats_b_d = dats_b_q;
    result_d = result_q;
    case (state_q)
      LOAD_A: begin
        if (in_hs) begin
          dats_a_d[int'(cnt_q)*DATA_SIZE +: DATA_SIZE] = in_data;
          cnt_d = (cnt_q == A_LAST) ? '0 : cnt_q + CNT_ONE;
        end
      end
      LOAD_B: begin
        if (in_hs) begin
          dats_b_d[int'(cnt_q)*DATA_SIZE +: DATA_SIZE] = in_data;
          cnt_d = (cnt_q == B_LAST) ? '0 : cnt_q + CNT_ONE;
        end
      end
      FIRE: begin
        cnt_d = '0;
      end
      WAIT: begin
        if (cnt_q == W_LAST) begin
          result_d = datsOut;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          cnt_d = (cnt_q == A_LAST) ? '0 : cnt_q + CNT_ONE;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == LOAD_A) || (state_q == LOAD_B);
    mat_enable = (state_q == FIRE);
    out_valid  = (state_q == DRAIN);
    out_last   = (state_q == DRAIN) && (cnt_q == A_LAST);
    out_data   = '0;
    if (state_q == DRAIN) begin
      out_data = result_q[int'(cnt_q)*DATA_SIZE +: DATA_SIZE];
    end
    busy = !((state_q == LOAD_A) && (cnt_q == '0));
  end

  assign datsA = dats_a_q;
  assign datsB = dats_b_q;

endmodule

// File: tb/tb_matrix_stream_io.sv
// Randomised bench for matrix_stream_io: streams vector+matrix words, plays the engine,
// and compares assembled buses and serialised results against a queue/array reference.
module tb_matrix_stream_io;

  localparam int DS    = 16;
  localparam int CS    = 2;
  localparam int RS    = 2;
  localparam int EL    = 1;
  localparam int AW    = DS * CS;
  localparam int BW    = DS * CS * RS;
  localparam int TOTAL = CS + CS * RS;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DS-1:0] in_data;
  logic [AW-1:0] datsA;
  logic [BW-1:0] datsB;
  logic          mat_enable;
  logic [AW-1:0] datsOut;
  logic          out_valid;
  logic          out_ready;
  logic [DS-1:0] out_data;
  logic          out_last;
  logic          busy;

  int checks;
  int passes;
  int pulseCount;
  logic [AW-1:0] engineResult;

  matrix_stream_io #(
    .DATA_SIZE(DS),
    .COLUMN_SIZE(CS),
    .ROW_SIZE(RS),
    .ENGINE_LATENCY(EL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .datsA(datsA),
    .datsB(datsB),
    .mat_enable(mat_enable),
    .datsOut(datsOut),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Engine stand-in: presents the result once it sees the start pulse, scribbles on the bus while draining.
  always @(negedge clock) begin
    if (mat_enable) begin
      datsOut = engineResult;
      pulseCount++;
    end else if (out_valid) begin
      datsOut = AW'($urandom);
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit directed, input int gapMode, input int stallCycles);
    logic [DS-1:0] words[TOTAL];
    logic [DS-1:0] res[CS];
    logic [AW-1:0] expA;
    logic [BW-1:0] expB;
    int idx;
    int guard;
    int stall;
    int startPulses;
    bit accepted;

    for (int i = 0; i < TOTAL; i++) words[i] = directed ? DS'(i + 1) : DS'($urandom);
    for (int i = 0; i < CS; i++) begin
      if (directed) res[i] = (i == 0) ? 16'h1234 : 16'hBEEF;
      else          res[i] = DS'($urandom);
    end
    expA = '0;
    expB = '0;
    for (int k = 0; k < CS; k++) expA[k*DS +: DS] = words[k];
    for (int j = 0; j < CS * RS; j++) expB[j*DS +: DS] = words[CS + j];
    engineResult = '0;
    for (int i = 0; i < CS; i++) engineResult[i*DS +: DS] = res[i];
    startPulses = pulseCount;

    idx   = 0;
    guard = 0;
    while (idx < TOTAL && guard < 500) begin
      @(negedge clock);
      case (gapMode)
        0:       in_valid = 1'b1;
        1:       in_valid = (guard % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? words[idx] : DS'($urandom);
      #1;
      checkOutput("in_ready_load", in_ready, 1);
      checkOutput("mat_enable_load", mat_enable, 0);
      checkOutput("out_valid_load", out_valid, 0);
      accepted = in_valid && in_ready;
      @(posedge clock);
      if (accepted) idx++;
      guard++;
    end
    if (idx < TOTAL) checkOutput("load_timeout", idx, TOTAL);

    @(negedge clock);
    in_valid = 1'b0;
    #1;
    checkOutput("mat_enable_fire", mat_enable, 1);
    checkOutput("datsA", datsA, expA);
    checkOutput("datsB", datsB, expB);
    checkOutput("in_ready_fire", in_ready, 0);
    checkOutput("busy_fire", busy, 1);

    for (int w = 0; w < EL; w++) begin
      @(negedge clock);
      #1;
      checkOutput("mat_enable_wait", mat_enable, 0);
      checkOutput("out_valid_wait", out_valid, 0);
      checkOutput("datsA_hold", datsA, expA);
      checkOutput("datsB_hold", datsB, expB);
    end

    for (int i = 0; i < CS; i++) begin
      stall = (stallCycles >= 0) ? stallCycles : int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) begin
        @(negedge clock);
        out_ready = 1'b0;
        #1;
        checkOutput("out_valid_stall", out_valid, 1);
        checkOutput("out_data_stall", out_data, res[i]);
        checkOutput("out_last_stall", out_last, (i == CS - 1));
        checkOutput("in_ready_stall", in_ready, 0);
      end
      @(negedge clock);
      out_ready = 1'b1;
      #1;
      checkOutput("out_valid", out_valid, 1);
      checkOutput("out_data", out_data, res[i]);
      checkOutput("out_last", out_last, (i == CS - 1));
    end

    @(negedge clock);
    #1;
    checkOutput("enable_pulses", pulseCount - startPulses, 1);
    checkOutput("in_ready_idle", in_ready, 1);
    checkOutput("busy_idle", busy, 0);
    checkOutput("out_valid_idle", out_valid, 0);
    checkOutput("datsA_keep", datsA, expA);
  endtask

  task automatic midLoadReset(input int wordsBefore);
    for (int i = 0; i < wordsBefore; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = DS'($urandom);
    end
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = DS'($urandom);
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_datsA", datsA, 0);
    checkOutput("rst_datsB", datsB, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks       = 0;
    passes       = 0;
    pulseCount   = 0;
    engineResult = '0;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b1;
    datsOut      = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_datsA", datsA, 0);
    checkOutput("reset_datsB", datsB, 0);
    checkOutput("reset_mat_enable", mat_enable, 0);
    checkOutput("reset_out_last", out_last, 0);
    checkOutput("reset_out_data", out_data, 0);

    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b1, 0, 5);
    applyStimulus(1'b1, 1, 0);
    midLoadReset(3);
    applyStimulus(1'b1, 0, 0);
    for (int t = 0; t < 15; t++) applyStimulus(1'b0, 2, -1);
    midLoadReset(5);
    applyStimulus(1'b0, 2, -1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
